// File: rtl/led_scan_ctrl_pkg.sv
// Shared constants for the LED row-scan controller.
package led_scan_ctrl_pkg;

    localparam int ROWS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_scan_ctrl_decode_3t8.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module decode_3t8 (
    input  logic       en,
    input  logic [2:0] a,
    output logic [7:0] b
);

    // one-hot select of output a when enabled
    always_comb begin
        b = 8'd0;
        if (en) begin
            b[a] = 1'b1;
        end
    end

endmodule

// File: rtl/led_scan_ctrl.sv
// Row-scan controller for an 8-row LED matrix with a double-buffered frame store.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | scan disabled, all outputs dark, row 0 / counter 0
//   ST_BLANK | all rows off between rows; front bank sampled on last cycle
//   ST_SHOW  | one row lit with the latched column pattern
module led_scan_ctrl
    import led_scan_ctrl_pkg::*;
#(
    parameter int COL_W     = 8,
    parameter int DWELL_CYC = 50000,
    parameter int BLANK_CYC = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [COL_W-1:0] wr_data,
    input  logic             swap_req,
    output logic             swap_pend,
    output logic             frame_start,
    output logic [2:0]       row_idx,
    output logic [7:0]       row_sel,
    output logic [COL_W-1:0] col_data
);

    localparam int CNT_W = $clog2(max_int(DWELL_CYC, BLANK_CYC) + 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       row_idx_nxt;
    logic             front, front_nxt;
    logic             back_sel;
    logic             swap_pend_nxt;
    logic             frame_start_nxt;
    logic [7:0]       row_sel_nxt;
    logic [COL_W-1:0] col_data_nxt;
    logic [COL_W-1:0] bank [2][ROWS];

    assign back_sel = ~front;

    // Decode from next-state values so the registered strobe lines up with the state
    // it belongs to (and goes dark the same cycle the FSM leaves SHOW).
    decode_3t8 u_decode (
        .en (state_nxt == ST_SHOW),
        .a  (row_idx_nxt),
        .b  (row_sel_nxt)
    );

    // next-state, counter, bank swap and output pattern
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        row_idx_nxt     = row_idx;
        front_nxt       = front;
        swap_pend_nxt   = swap_pend | swap_req;
        frame_start_nxt = 1'b0;
        col_data_nxt    = col_data;

        if (!en) begin
            state_nxt    = ST_IDLE;
            cnt_nxt      = '0;
            row_idx_nxt  = 3'd0;
            col_data_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt       = ST_BLANK;
                    cnt_nxt         = '0;
                    row_idx_nxt     = 3'd0;
                    frame_start_nxt = 1'b1;
                    col_data_nxt    = '0;
                end
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_nxt    = ST_SHOW;
                        cnt_nxt      = '0;
                        col_data_nxt = bank[front][row_idx];
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt == DWELL_LAST) begin
                        state_nxt    = ST_BLANK;
                        cnt_nxt      = '0;
                        row_idx_nxt  = row_idx + 3'd1;
                        col_data_nxt = '0;
                        // frame boundary: swap takes effect before row 0 is sampled
                        if (row_idx == 3'd7) begin
                            frame_start_nxt = 1'b1;
                            if (swap_pend || swap_req) begin
                                front_nxt     = ~front;
                                swap_pend_nxt = 1'b0;
                            end
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt    = ST_IDLE;
                    cnt_nxt      = '0;
                    row_idx_nxt  = 3'd0;
                    col_data_nxt = '0;
                end
            endcase
        end
    end

    // state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            row_idx     <= 3'd0;
            front       <= 1'b0;
            swap_pend   <= 1'b0;
            frame_start <= 1'b0;
            row_sel     <= 8'd0;
            col_data    <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            row_idx     <= row_idx_nxt;
            front       <= front_nxt;
            swap_pend   <= swap_pend_nxt;
            frame_start <= frame_start_nxt;
            row_sel     <= row_sel_nxt;
            col_data    <= col_data_nxt;
        end
    end

    // Back-bank writes use the pre-flip selection, so a write coincident with a swap
    // lands in the bank that is about to become the front.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    bank[b][r] <= '0;
                end
            end
        end else if (wr_en) begin
            bank[back_sel][wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl with DWELL_CYC=4, BLANK_CYC=2 (row period 6, frame 48).
module tb_led_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [7:0] wr_data = 8'd0;
    logic       swap_req = 1'b0;
    logic       swap_pend;
    logic       frame_start;
    logic [2:0] row_idx;
    logic [7:0] row_sel;
    logic [7:0] col_data;

    int checks = 0;
    int errors = 0;
    int kc = 0;

    always #5 clk = ~clk;

    led_scan_ctrl #(.COL_W(8), .DWELL_CYC(4), .BLANK_CYC(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
        .swap_pend   (swap_pend),
        .frame_start (frame_start),
        .row_idx     (row_idx),
        .row_sel     (row_sel),
        .col_data    (col_data)
    );

    // inputs change and outputs are sampled on the falling edge
    task automatic adv(input int n);
        repeat (n) @(negedge clk);
        kc += n;
    endtask

    function automatic bit is_show(input int k);
        return ((k % 48) % 6) >= 2;
    endfunction

    function automatic int row_of(input int k);
        return (k % 48) / 6;
    endfunction

    function automatic logic [7:0] exp_sel(input int k);
        return is_show(k) ? 8'(1 << row_of(k)) : 8'd0;
    endfunction

    task automatic test_reset();
        int fs_seen;
        fs_seen = 0;
        rst = 1'b1; en = 1'b0;
        adv(2);
        rst = 1'b0;
        checks++; if (row_sel !== 8'd0) begin errors++; $display("FAIL reset_row_sel got %h exp 00", row_sel); end
        checks++; if (col_data !== 8'd0) begin errors++; $display("FAIL reset_col_data got %h exp 00", col_data); end
        checks++; if (row_idx !== 3'd0) begin errors++; $display("FAIL reset_row_idx got %0d exp 0", row_idx); end
        checks++; if (swap_pend !== 1'b0) begin errors++; $display("FAIL reset_swap_pend got %b exp 0", swap_pend); end
        for (int i = 0; i < 100; i++) begin
            adv(1);
            if (frame_start === 1'b1) fs_seen++;
            checks++; if (row_sel !== 8'd0 || col_data !== 8'd0) begin
                errors++; $display("FAIL idle_dark cyc %0d row_sel %h col %h exp 00 00", i, row_sel, col_data);
            end
        end
        checks++; if (fs_seen != 0) begin errors++; $display("FAIL idle_frame_start pulses %0d exp 0", fs_seen); end
    endtask

    task automatic test_scan();
        logic [7:0] exp_col;
        for (int r = 0; r < 8; r++) begin
            wr_en = 1'b1; wr_addr = 3'(r); wr_data = 8'(r + 1);
            adv(1);
        end
        wr_en = 1'b0;
        swap_req = 1'b1; adv(1); swap_req = 1'b0;
        checks++; if (swap_pend !== 1'b1) begin errors++; $display("FAIL scan_pend_idle got %b exp 1", swap_pend); end
        en = 1'b1; adv(1); kc = 0;
        for (int k = 0; k < 96; k++) begin
            exp_col = (is_show(k) && k >= 48) ? 8'(row_of(k) + 1) : 8'd0;
            checks++; if (row_sel !== exp_sel(k)) begin errors++; $display("FAIL scan_row_sel k %0d got %h exp %h", k, row_sel, exp_sel(k)); end
            checks++; if (col_data !== exp_col) begin errors++; $display("FAIL scan_col k %0d got %h exp %h", k, col_data, exp_col); end
            checks++; if (row_idx !== 3'(row_of(k))) begin errors++; $display("FAIL scan_row_idx k %0d got %0d exp %0d", k, row_idx, row_of(k)); end
            checks++; if (frame_start !== ((k % 48) == 0)) begin errors++; $display("FAIL scan_frame_start k %0d got %b", k, frame_start); end
            checks++; if (swap_pend !== (k < 48)) begin errors++; $display("FAIL scan_swap_pend k %0d got %b exp %b", k, swap_pend, k < 48); end
            adv(1);
        end
    endtask

    task automatic test_double_swap();
        logic [7:0] exp_col;
        en = 1'b0; adv(1);
        for (int r = 0; r < 8; r++) begin
            wr_en = 1'b1; wr_addr = 3'(r); wr_data = 8'(8'h10 + r);
            adv(1);
        end
        wr_en = 1'b0;
        en = 1'b1; adv(1); kc = 0;
        for (int k = 0; k < 100; k++) begin
            exp_col = !is_show(k) ? 8'd0 : (k < 48) ? 8'(row_of(k) + 1) : 8'(8'h10 + row_of(k));
            checks++; if (swap_pend !== (k >= 11 && k < 48)) begin errors++; $display("FAIL dbl_swap_pend k %0d got %b exp %b", k, swap_pend, (k >= 11 && k < 48)); end
            checks++; if (col_data !== exp_col) begin errors++; $display("FAIL dbl_swap_col k %0d got %h exp %h", k, col_data, exp_col); end
            swap_req = (k == 10 || k == 20);
            adv(1);
        end
        swap_req = 1'b0;
    endtask

    task automatic test_disable();
        en = 1'b0; adv(1);
        en = 1'b1; adv(1); kc = 0;
        for (int k = 0; k < 33; k++) begin
            swap_req = (k == 20);
            adv(1);
        end
        swap_req = 1'b0;
        checks++; if (row_sel !== 8'h20) begin errors++; $display("FAIL dis_row5_sel got %h exp 20", row_sel); end
        checks++; if (col_data !== 8'h15) begin errors++; $display("FAIL dis_row5_col got %h exp 15", col_data); end
        en = 1'b0; adv(1);
        checks++; if (row_sel !== 8'd0) begin errors++; $display("FAIL dis_row_sel got %h exp 00", row_sel); end
        checks++; if (col_data !== 8'd0) begin errors++; $display("FAIL dis_col got %h exp 00", col_data); end
        checks++; if (row_idx !== 3'd0) begin errors++; $display("FAIL dis_row_idx got %0d exp 0", row_idx); end
        checks++; if (swap_pend !== 1'b1) begin errors++; $display("FAIL dis_pend_kept got %b exp 1", swap_pend); end
        adv(3);
        checks++; if (row_sel !== 8'd0 || frame_start !== 1'b0) begin errors++; $display("FAIL dis_idle_hold sel %h fs %b exp 00 0", row_sel, frame_start); end
        en = 1'b1; adv(1); kc = 0;
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL reen_frame_start got %b exp 1", frame_start); end
        checks++; if (row_idx !== 3'd0 || row_sel !== 8'd0) begin errors++; $display("FAIL reen_blank idx %0d sel %h exp 0 00", row_idx, row_sel); end
        adv(2);
        checks++; if (row_sel !== 8'h01 || col_data !== 8'h10) begin errors++; $display("FAIL reen_row0 sel %h col %h exp 01 10", row_sel, col_data); end
    endtask

    task automatic test_write_lit();
        adv(66);
        checks++; if (row_sel !== 8'h08 || col_data !== 8'h04) begin errors++; $display("FAIL lit_row3 sel %h col %h exp 08 04", row_sel, col_data); end
        checks++; if (swap_pend !== 1'b0) begin errors++; $display("FAIL lit_pend got %b exp 0", swap_pend); end
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
        adv(1);
        wr_en = 1'b0;
        checks++; if (col_data !== 8'h04) begin errors++; $display("FAIL lit_col_held got %h exp 04", col_data); end
        adv(26);
        checks++; if (row_idx !== 3'd7 || row_sel !== 8'h80) begin errors++; $display("FAIL pre_wrap idx %0d sel %h exp 7 80", row_idx, row_sel); end
        swap_req = 1'b1; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h5A;
        adv(1);
        swap_req = 1'b0; wr_en = 1'b0;
        checks++; if (frame_start !== 1'b1 || swap_pend !== 1'b0) begin errors++; $display("FAIL wrap_swap fs %b pend %b exp 1 0", frame_start, swap_pend); end
        adv(14);
        checks++; if (col_data !== 8'h12) begin errors++; $display("FAIL new_front_row2 got %h exp 12", col_data); end
        adv(6);
        checks++; if (row_sel !== 8'h08 || col_data !== 8'h5A) begin errors++; $display("FAIL coincident_write sel %h col %h exp 08 5a", row_sel, col_data); end
    endtask

    task automatic test_reset_mid();
        swap_req = 1'b1; adv(1); swap_req = 1'b0;
        checks++; if (swap_pend !== 1'b1 || row_sel !== 8'h08) begin errors++; $display("FAIL pre_rst pend %b sel %h exp 1 08", swap_pend, row_sel); end
        #2 rst = 1'b1;
        #1;
        checks++; if (row_sel !== 8'd0 || col_data !== 8'd0) begin errors++; $display("FAIL rst_async_out sel %h col %h exp 00 00", row_sel, col_data); end
        checks++; if (swap_pend !== 1'b0 || row_idx !== 3'd0) begin errors++; $display("FAIL rst_async_state pend %b idx %0d exp 0 0", swap_pend, row_idx); end
        adv(1);
        rst = 1'b0;
        adv(1); kc = 0;
        for (int k = 0; k < 96; k++) begin
            checks++; if (row_sel !== exp_sel(k) || col_data !== 8'd0) begin
                errors++; $display("FAIL banks_cleared k %0d sel %h col %h exp %h 00", k, row_sel, col_data, exp_sel(k));
            end
            swap_req = (k == 0);
            adv(1);
        end
        swap_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_double_swap();
        test_disable();
        test_write_lit();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
